// File: rtl/serial_word_transmitter_pkg.sv
// Shared definitions for the bit-serial link transmitter.
// Holds the default word/timing parameters used by both link ends, the FSM state
// encoding, and a small helper for sizing counters.
package serial_word_transmitter_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_HOLD  = 10;
  localparam int unsigned DEF_GAP   = 10;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE     = 2'd0;
  localparam tx_state_t WAIT_RDY = 2'd1;
  localparam tx_state_t BIT_HIGH = 2'd2;
  localparam tx_state_t BIT_LOW  = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_word_transmitter_if.sv
// Host/link-side signal bundle of the serial word transmitter.
// Ports (as seen by the transmitter, modport slave):
//   enqueue_in, data_in  : word push strobe and word
//   full_out, len_out    : FIFO full flag and occupancy
//   status_in            : receiver ready for a new word
//   data_out, write_out  : serial bit and its strobe
//   busy_out             : word in flight
interface serial_word_transmitter_if
  import serial_word_transmitter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned LenW = $clog2(DEPTH + 1);

  logic             enqueue_in;
  logic [WIDTH-1:0] data_in;
  logic             full_out;
  logic [LenW-1:0]  len_out;
  logic             status_in;
  logic             data_out;
  logic             write_out;
  logic             busy_out;

  modport master (
    output enqueue_in, data_in, status_in,
    input  full_out, len_out, data_out, write_out, busy_out
  );

  modport slave (
    input  enqueue_in, data_in, status_in,
    output full_out, len_out, data_out, write_out, busy_out
  );
endinterface

// File: rtl/serial_word_transmitter_tx_word_fifo.sv
// Transmit word FIFO, DEPTH x WIDTH, DEPTH a power of two.
// Ports: clock, reset (sync, active-high), push/push_data (ignored while full),
// pop (ignored while empty), head (word at read pointer), len and full (registered).
module tx_word_fifo
  import serial_word_transmitter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   len,
  output logic                         full
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LenW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LenW-1:0]  len_q, len_d;
  logic             full_q;
  logic             push_ok, pop_ok;

  // A push while full is dropped even if a pop frees a slot this same cycle.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && (len_q != '0);

  always_comb begin
    len_d = len_q;
    unique case ({push_ok, pop_ok})
      2'b10:   len_d = len_q + LenW'(1);
      2'b01:   len_d = len_q - LenW'(1);
      default: len_d = len_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      len_q  <= len_d;
      full_q <= (len_d == LenW'(DEPTH));
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head = mem_q[rd_ptr_q];
  assign len  = len_q;
  assign full = full_q;
endmodule

// File: rtl/serial_word_transmitter.sv
// Transmit side of the bit-serial link: queues parallel words and shifts each one out
// LSB first as strobed pulses (write_out high HOLD_CYCLES, low GAP_CYCLES per bit).
// A word starts only after the receiver reports ready on status_in.
// Ports: clock, reset (sync, active-high), bus (slave modport of serial_word_transmitter_if).
module serial_word_transmitter
  import serial_word_transmitter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD,
  parameter int unsigned GAP_CYCLES  = DEF_GAP
) (
  input logic                        clock,
  input logic                        reset,
  serial_word_transmitter_if.slave   bus
);
  localparam int unsigned CycW = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CycW-1:0]  cyc_q, cyc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             write_q, data_q, busy_q;

  logic [WIDTH-1:0]             head;
  logic [$clog2(DEPTH+1)-1:0]   len;
  logic                         full;
  logic                         pop;

  tx_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.enqueue_in),
    .push_data (bus.data_in),
    .pop       (pop),
    .head      (head),
    .len       (len),
    .full      (full)
  );

  assign pop = (state_q == IDLE) && (len != '0);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d = head;
          idx_d   = '0;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.status_in) begin
          cyc_d   = '0;
          state_d = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        if (cyc_q == CycW'(HOLD_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = BIT_LOW;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      BIT_LOW: begin
        if (cyc_q == CycW'(GAP_CYCLES - 1)) begin
          cyc_d = '0;
          if (idx_q == IdxW'(WIDTH - 1)) begin
            state_d = IDLE;
          end else begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + IdxW'(1);
            state_d = BIT_HIGH;
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies of the current state, so they lag the state by one
  // cycle; this keeps them glitch-free and sets the status-to-first-strobe latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      write_q <= (state_q == BIT_HIGH);
      if (state_q == BIT_HIGH) data_q <= shreg_q[0];
      busy_q  <= (state_q != IDLE);
    end
  end

  assign bus.write_out = write_q;
  assign bus.data_out  = data_q;
  assign bus.busy_out  = busy_q;
  assign bus.len_out   = len;
  assign bus.full_out  = full;
endmodule

// File: tb/tb_serial_word_transmitter.sv
// Directed bench for serial_word_transmitter with 8-bit words, 4-entry FIFO, 10/10 timing.
module tb_serial_word_transmitter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  serial_word_transmitter_if #(.WIDTH(8), .DEPTH(4)) bus ();

  serial_word_transmitter #(
    .WIDTH       (8),
    .DEPTH       (4),
    .HOLD_CYCLES (10),
    .GAP_CYCLES  (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Pulse monitor: edge index of each rise/fall of write_out and the bit seen at the rise.
  logic bits_q [$];
  int   rise_q [$];
  int   fall_q [$];
  int   busy_fall = -1;
  logic wr_prev = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clock) begin
    if (bus.write_out === 1'b1 && wr_prev === 1'b0) begin
      bits_q.push_back(bus.data_out);
      rise_q.push_back(cyc_cnt);
    end
    if (bus.write_out === 1'b0 && wr_prev === 1'b1) fall_q.push_back(cyc_cnt);
    if (bus.busy_out === 1'b0 && busy_prev === 1'b1) busy_fall = cyc_cnt;
    wr_prev   = bus.write_out;
    busy_prev = bus.busy_out;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Returns the edge index at which the word was sampled.
  task automatic enqueue(input logic [7:0] w, output int edge_n);
    bus.enqueue_in = 1'b1;
    bus.data_in    = w;
    tick();
    edge_n = cyc_cnt;
    bus.enqueue_in = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int target, input bit on_rise,
                             input int budget);
    int n = 0;
    while (((on_rise ? rise_q.size() : fall_q.size()) < target) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_tmo"}, 32'((on_rise ? rise_q.size() : fall_q.size()) >= target), 32'd1);
  endtask

  task automatic check_word(input string tag, input int base, input logic [7:0] exp);
    logic [7:0] w = '0;
    int bad_hi = 0;
    int bad_lo = 0;
    if (fall_q.size() < base + 8) begin
      check_eq({tag, "_count"}, 32'(fall_q.size()), 32'(base + 8));
      return;
    end
    for (int i = 0; i < 8; i++) begin
      w[i] = bits_q[base + i];
      if (fall_q[base + i] - rise_q[base + i] != 10) bad_hi++;
      if (i < 7 && rise_q[base + i + 1] - fall_q[base + i] != 10) bad_lo++;
    end
    check_eq({tag, "_data"}, 32'(w), 32'(exp));
    check_eq({tag, "_hi_bad"}, 32'(bad_hi), 32'd0);
    check_eq({tag, "_lo_bad"}, 32'(bad_lo), 32'd0);
  endtask

  initial begin
    int e;
    int base;
    int m;
    bus.enqueue_in = 1'b0;
    bus.data_in    = '0;
    bus.status_in  = 1'b0;

    // 1. Reset held three cycles.
    tick(3);
    reset = 1'b0;
    check_eq("rst_write", 32'(bus.write_out), 32'd0);
    check_eq("rst_data", 32'(bus.data_out), 32'd0);
    check_eq("rst_busy", 32'(bus.busy_out), 32'd0);
    check_eq("rst_len", 32'(bus.len_out), 32'd0);
    check_eq("rst_full", 32'(bus.full_out), 32'd0);
    tick(50);
    check_eq("rst_quiet", 32'(rise_q.size()), 32'd0);

    // 2. Single word 0x99, receiver ready.
    bus.status_in = 1'b1;
    base = rise_q.size();
    enqueue(8'h99, e);
    wait_pulses("w99", base + 8, 1'b0, 400);
    tick(15);
    check_word("w99", base, 8'h99);
    check_eq("w99_latency", 32'(rise_q[base]), 32'(e + 3));
    check_eq("w99_busy_fall", 32'(busy_fall - rise_q[base]), 32'd160);

    // 3. Receiver not ready: word waits, starts one edge after status is sampled high.
    bus.status_in = 1'b0;
    base = rise_q.size();
    enqueue(8'hA5, e);
    tick(40);
    check_eq("wa5_hold", 32'(rise_q.size()), 32'(base));
    check_eq("wa5_busy_wait", 32'(bus.busy_out), 32'd1);
    bus.status_in = 1'b1;
    m = cyc_cnt + 1;
    wait_pulses("wa5", base + 8, 1'b0, 400);
    tick(15);
    check_word("wa5", base, 8'hA5);
    check_eq("wa5_start", 32'(rise_q[base]), 32'(m + 1));

    // 4. Five back-to-back words; word 1 pops straight away, so 2..5 fill the FIFO.
    base = rise_q.size();
    enqueue(8'h01, e);
    check_eq("q1_len", 32'(bus.len_out), 32'd1);
    enqueue(8'h02, e);
    check_eq("q2_len", 32'(bus.len_out), 32'd1);
    enqueue(8'h03, e);
    check_eq("q3_len", 32'(bus.len_out), 32'd2);
    enqueue(8'h04, e);
    check_eq("q4_len", 32'(bus.len_out), 32'd3);
    check_eq("q4_full", 32'(bus.full_out), 32'd0);
    enqueue(8'h05, e);
    check_eq("q5_len", 32'(bus.len_out), 32'd4);
    check_eq("q5_full", 32'(bus.full_out), 32'd1);
    enqueue(8'h06, e);
    check_eq("q6_len", 32'(bus.len_out), 32'd4);
    check_eq("q6_full", 32'(bus.full_out), 32'd1);
    wait_pulses("q", base + 40, 1'b0, 2500);
    tick(200);
    check_eq("q_total", 32'(rise_q.size()), 32'(base + 40));
    for (int k = 0; k < 5; k++) check_word($sformatf("q%0d", k + 1), base + 8 * k, 8'(k + 1));

    // 5. Status dropped mid-word: word completes, next word waits for ready.
    base = rise_q.size();
    enqueue(8'h3C, e);
    enqueue(8'hC3, e);
    wait_pulses("w3c_b3", base + 4, 1'b1, 200);
    bus.status_in = 1'b0;
    wait_pulses("w3c", base + 8, 1'b0, 400);
    tick(60);
    check_word("w3c", base, 8'h3C);
    check_eq("wc3_hold", 32'(rise_q.size()), 32'(base + 8));
    check_eq("wc3_busy_wait", 32'(bus.busy_out), 32'd1);
    check_eq("wc3_len", 32'(bus.len_out), 32'd0);
    bus.status_in = 1'b1;
    wait_pulses("wc3", base + 16, 1'b0, 400);
    tick(15);
    check_word("wc3", base + 8, 8'hC3);

    // 6. Reset during bit 5 of 0xFF with two words still queued.
    base = rise_q.size();
    enqueue(8'hFF, e);
    enqueue(8'h11, e);
    enqueue(8'h22, e);
    check_eq("r_len_pre", 32'(bus.len_out), 32'd2);
    wait_pulses("r_b5", base + 6, 1'b1, 300);
    tick(3);
    check_eq("r_write_pre", 32'(bus.write_out), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("r_write", 32'(bus.write_out), 32'd0);
    check_eq("r_len", 32'(bus.len_out), 32'd0);
    check_eq("r_busy", 32'(bus.busy_out), 32'd0);
    check_eq("r_full", 32'(bus.full_out), 32'd0);
    reset = 1'b0;
    tick(400);
    check_eq("r_quiet", 32'(rise_q.size()), 32'(base + 6));
    check_eq("r_len_post", 32'(bus.len_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
